// File: rtl/lpc_encode_avalon_ctl.sv
`timescale 1ns/1ps
// lpc_encode_avalon_ctl
// Avalon-MM slave front-end for an lpc_encode-style core. Maps the sample,
// residue and coefficient stores plus a small control/status block into one
// word-address space and sequences a frame run with busy protection.
module lpc_encode_avalon_ctl #(
    parameter int FRAME_LEN = 160,
    parameter int ORDER     = 10,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    localparam int IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic              core_start,
    input  logic              core_rready,
    output logic              core_x_wen,
    output logic [IDX_W-1:0]  core_x_waddr,
    output logic [IDX_W-1:0]  core_x_raddr,
    output logic [DATA_W-1:0] core_x_din,
    input  logic [DATA_W-1:0] core_x_dout,
    output logic [IDX_W-1:0]  core_res_raddr,
    input  logic [DATA_W-1:0] core_res_dout,
    output logic [ORDER-1:0]  core_a_rsel,
    input  logic [31:0]       core_a_dout
);

    // Region bases, all derived from the frame length and LPC order.
    localparam logic [ADDR_W-1:0] R_BASE = ADDR_W'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(2 * FRAME_LEN);
    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(2 * FRAME_LEN + 2 * ORDER);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic               first_run_r;
    logic [31:0]        cyc_run_r;
    logic [31:0]        cyc_r;
    logic [15:0]        frame_cnt_r;
    logic               core_start_r;
    logic               done_sticky_r;
    logic               err_sticky_r;
    logic [1:0]         irq_en_r;
    logic               irq_r;
    logic [DATA_W-1:0]  readdata_r;

    logic               x_hit_s;
    logic               res_hit_s;
    logic               a_hit_s;
    logic               ctl_hit_s;
    logic [ADDR_W-1:0]  c_off_s;
    logic [ADDR_W-1:0]  a_off_s;
    logic [ADDR_W-1:0]  a_idx_s;
    logic               wr_s;
    logic               rd_s;
    logic               busy_s;
    logic               start_req_s;
    logic               start_ok_s;
    logic               start_err_s;
    logic               x_wr_s;
    logic               err_set_s;
    logic               done_set_s;
    logic               done_clr_s;
    logic               err_clr_s;
    logic               en_wr_s;
    logic [DATA_W-1:0]  rd_mux_s;

    // Address decode: every region is a half-open range above its base.
    assign x_hit_s   = (address < R_BASE);
    assign res_hit_s = (address >= R_BASE) && (address < A_BASE);
    assign a_hit_s   = (address >= A_BASE) && (address < C_BASE);
    assign c_off_s   = address - C_BASE;
    assign ctl_hit_s = (address >= C_BASE) && (c_off_s < ADDR_W'(3'd6));
    assign a_off_s   = address - A_BASE;
    assign a_idx_s   = a_off_s >> 1;

    assign wr_s   = chipselect & write;
    assign rd_s   = chipselect & read;
    assign busy_s = (state_r != ST_IDLE);

    // Start handling: a start in the DONE cycle is silently dropped, any
    // other start while busy is flagged.
    assign start_req_s = wr_s & ctl_hit_s & (c_off_s == ADDR_W'(3'd0)) & writedata[0];
    assign start_ok_s  = start_req_s & (state_r == ST_IDLE);
    assign start_err_s = start_req_s & busy_s & (state_r != ST_DONE);

    assign x_wr_s     = wr_s & x_hit_s;
    assign err_set_s  = start_err_s | (x_wr_s & busy_s) | (wr_s & (res_hit_s | a_hit_s));
    assign done_set_s = (state_r == ST_DONE);
    assign done_clr_s = wr_s & ctl_hit_s & (c_off_s == ADDR_W'(3'd1)) & writedata[2];
    assign err_clr_s  = wr_s & ctl_hit_s & (c_off_s == ADDR_W'(3'd1)) & writedata[3];
    assign en_wr_s    = wr_s & ctl_hit_s & (c_off_s == ADDR_W'(3'd2));

    // Core-side store access is combinational so the core sees the bus cycle directly.
    assign core_x_wen     = x_wr_s & ~busy_s;
    assign core_x_waddr   = address[IDX_W-1:0];
    assign core_x_raddr   = address[IDX_W-1:0];
    assign core_x_din     = writedata;
    assign core_res_raddr = IDX_W'(address - R_BASE);
    assign core_a_rsel    = a_hit_s ? (ORDER'(1'b1) << a_idx_s) : {ORDER{1'b0}};

    assign core_start = core_start_r;
    assign irq        = irq_r;
    assign readdata   = readdata_r;

    // Read-data selection for the registered read port.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        if (x_hit_s) begin
            rd_mux_s = core_x_dout;
        end else if (res_hit_s) begin
            rd_mux_s = core_res_dout;
        end else if (a_hit_s) begin
            if (a_off_s[0]) begin
                rd_mux_s = DATA_W'(core_a_dout[31:16]);
            end else begin
                rd_mux_s = DATA_W'(core_a_dout[15:0]);
            end
        end else if (ctl_hit_s) begin
            case (c_off_s)
                ADDR_W'(3'd1): rd_mux_s = DATA_W'({12'h000, err_sticky_r, done_sticky_r,
                                                   busy_s, core_rready});
                ADDR_W'(3'd2): rd_mux_s = DATA_W'({14'h0000, irq_en_r});
                ADDR_W'(3'd3): rd_mux_s = DATA_W'(frame_cnt_r);
                ADDR_W'(3'd4): rd_mux_s = DATA_W'(cyc_r[15:0]);
                ADDR_W'(3'd5): rd_mux_s = DATA_W'(cyc_r[31:16]);
                default:       rd_mux_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rd_mux_s = {DATA_W{1'b0}};
        end
    end

    // Frame sequencer: launch pulse, cycle counting, completion bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            first_run_r  <= 1'b0;
            cyc_run_r    <= 32'd0;
            cyc_r        <= 32'd0;
            frame_cnt_r  <= 16'd0;
            core_start_r <= 1'b0;
        end else begin
            core_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_r      <= ST_LAUNCH;
                        core_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    cyc_run_r   <= 32'd0;
                    first_run_r <= 1'b1;
                    state_r     <= ST_RUN;
                end
                ST_RUN: begin
                    first_run_r <= 1'b0;
                    // The exit cycle is not counted, so CYC reports N-1 for a
                    // core that answers N cycles after its start pulse.
                    if (!first_run_r && core_rready) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                        if (cyc_run_r != {32{1'b1}}) begin
                            cyc_run_r <= cyc_run_r + 32'd1;
                        end else begin
                            cyc_run_r <= cyc_run_r;
                        end
                    end
                end
                ST_DONE: begin
                    cyc_r       <= cyc_run_r;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky status, interrupt enables and the registered interrupt line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_sticky_r <= 1'b0;
            err_sticky_r  <= 1'b0;
            irq_en_r      <= 2'b00;
            irq_r         <= 1'b0;
        end else begin
            done_sticky_r <= done_set_s | (done_sticky_r & ~done_clr_s);
            err_sticky_r  <= err_set_s  | (err_sticky_r  & ~err_clr_s);
            if (en_wr_s) begin
                irq_en_r <= writedata[1:0];
            end else begin
                irq_en_r <= irq_en_r;
            end
            irq_r <= (done_sticky_r & irq_en_r[0]) | (err_sticky_r & irq_en_r[1]);
        end
    end

    // Read port: capture on a read strobe, hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= {DATA_W{1'b0}};
        end else if (rd_s) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

endmodule

// File: tb/tb_lpc_encode_avalon_ctl.sv
`timescale 1ns/1ps
// Scoreboard bench for lpc_encode_avalon_ctl: random bus traffic against a
// behavioural model of the register map, plus a small core model.
module tb_lpc_encode_avalon_ctl;
    localparam int F  = 160;
    localparam int O  = 10;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int AB = 2 * F;
    localparam int CB = 2 * F + 2 * O;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, cs, rd, wr, irq, core_start, core_rready, core_x_wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, readdata, x_din, x_dout, res_dout;
    logic [7:0]    x_waddr, x_raddr, res_raddr;
    logic [O-1:0]  a_rsel;
    logic [31:0]   a_dout;

    lpc_encode_avalon_ctl #(.FRAME_LEN(F), .ORDER(O), .DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clock(clock), .reset_n(reset_n), .chipselect(cs), .read(rd), .write(wr),
        .address(addr), .writedata(wdata), .readdata(readdata), .irq(irq),
        .core_start(core_start), .core_rready(core_rready), .core_x_wen(core_x_wen),
        .core_x_waddr(x_waddr), .core_x_raddr(x_raddr), .core_x_din(x_din),
        .core_x_dout(x_dout), .core_res_raddr(res_raddr), .core_res_dout(res_dout),
        .core_a_rsel(a_rsel), .core_a_dout(a_dout));

    // ---------------- core model ----------------
    logic [15:0] xmem [F];
    logic [31:0] coef [O];
    int n_cfg = 2;
    int rcnt;
    logic rdy;
    int start_cnt = 0;

    always @(posedge clock) if (core_x_wen) xmem[x_waddr] <= x_din;
    assign x_dout   = xmem[x_raddr];
    assign res_dout = {res_raddr, ~res_raddr};
    always_comb begin
        a_dout = 32'h0;
        for (int i = 0; i < O; i++) if (a_rsel[i]) a_dout = a_dout | coef[i];
    end
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rcnt <= 0; rdy <= 1'b0;
        end else if (core_start) begin
            rcnt <= 1; rdy <= 1'b0;
        end else if (rcnt != 0) begin
            rcnt <= rcnt + 1;
            if (rcnt + 1 == n_cfg) rdy <= 1'b1;
        end
    end
    assign core_rready = rdy;
    always @(posedge clock) if (core_start) start_cnt <= start_cnt + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int tag_q[$];
    logic rvalid_d = 1'b0;
    logic [DW-1:0] mon_e;
    int mon_t;

    always @(posedge clock) rvalid_d <= cs & rd;
    always @(negedge clock) begin
        if (rvalid_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%h", readdata);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                if (readdata !== mon_e) begin
                    errors++;
                    $display("FAIL rd addr=%0d got=%h exp=%h", mon_t, readdata, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [15:0] x_ref [F];
    logic        err_m, done_m, rready_m;
    logic [1:0]  en_m;
    logic [15:0] fcnt_m;
    logic [31:0] cyc_m;

    function automatic logic [15:0] exp_rd(input int a);
        logic [7:0]  i8;
        logic [31:0] w;
        if (a < F) return x_ref[a];
        if (a < AB) begin
            i8 = 8'(a - F);
            return {i8, ~i8};
        end
        if (a < CB) begin
            w = coef[(a - AB) / 2];
            return ((a - AB) % 2 == 1) ? w[31:16] : w[15:0];
        end
        case (a - CB)
            1: return {12'h000, err_m, done_m, 1'b0, rready_m};
            2: return {14'h0000, en_m};
            3: return fcnt_m;
            4: return cyc_m[15:0];
            5: return cyc_m[31:16];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic irq_f();
        return (done_m & en_m[0]) | (err_m & en_m[1]);
    endfunction

    // ---------------- bus tasks (called at posedge+1) ----------------
    task automatic cyc_end();
        @(posedge clock); #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_op(input int a, input logic [15:0] e);
        addr = AW'(a); cs = 1'b1; rd = 1'b1; wr = 1'b0;
        exp_q.push_back(e); tag_q.push_back(a);
        #1;
        cyc_end();
    endtask

    task automatic wr_op(input int a, input logic [15:0] d, output logic wen, output logic [7:0] wa);
        addr = AW'(a); wdata = d; cs = 1'b1; rd = 1'b0; wr = 1'b1;
        #1;
        wen = core_x_wen; wa = x_waddr;
        cyc_end();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_end();
    endtask

    // One frame; mode 0 plain, 1 busy-protection, 2 start in DONE, 3 W1C done in DONE.
    task automatic run_frame(input int n, input int mode);
        int s0;
        logic err_vis, wen, busy_k, rdy_k, done_k;
        logic [7:0] wa;
        logic [15:0] st;
        n_cfg = n;
        wr_op(CB + 1, 16'h0008, wen, wa);
        err_m = 1'b0;
        s0 = start_cnt;
        wr_op(CB, 16'h0001, wen, wa);
        err_vis = 1'b0;
        for (int k = 0; k <= n + 3; k++) begin
            if (k == 0) chk("core_start_hi", core_start, 1);
            if (k == 1) chk("core_start_lo", core_start, 0);
            busy_k = (k <= n + 1);
            rdy_k  = (k == 0) ? rready_m : (k >= n);
            done_k = done_m | (k >= n + 2);
            st = {12'h000, err_vis, done_k, busy_k, rdy_k};
            if (mode == 1 && k == 3) begin
                wr_op(3, 16'h5555, wen, wa);
                chk("x_wen_busy", wen, 0);
                err_vis = 1'b1;
            end else if (mode == 1 && k == 4) begin
                wr_op(CB, 16'h0001, wen, wa);
                err_vis = 1'b1;
            end else if (mode == 2 && k == n + 1) begin
                wr_op(CB, 16'h0001, wen, wa);
            end else if (mode == 3 && k == n + 1) begin
                wr_op(CB + 1, 16'h0004, wen, wa);
            end else begin
                rd_op(CB + 1, st);
            end
        end
        chk("start_pulses", start_cnt - s0, 1);
        fcnt_m = fcnt_m + 16'd1;
        cyc_m = 32'(n - 1);
        done_m = 1'b1;
        err_m = err_vis;
        rready_m = 1'b1;
        rd_op(CB + 3, exp_rd(CB + 3));
        rd_op(CB + 4, exp_rd(CB + 4));
        rd_op(CB + 5, exp_rd(CB + 5));
        rd_op(CB + 1, exp_rd(CB + 1));
        idle(1);
        chk("irq_after_frame", irq, irq_f());
    endtask

    // ---------------- second configuration (FRAME_LEN=256, ORDER=16) ----------------
    localparam int F2 = 256;
    localparam int O2 = 16;
    localparam int AW2 = 10;
    localparam int CB2 = 2 * F2 + 2 * O2;
    logic cs_b, read_b, write_b, irq_b, start_b, rready_b, wen_b;
    logic [AW2-1:0] addr_b;
    logic [15:0] wdata_b, rdata_b, xdout_b, xdin_b;
    logic [7:0] xwa_b, xra_b, rra_b;
    logic [O2-1:0] rsel_b;
    logic [31:0] adout_b;
    logic [15:0] xmem_b [F2];
    int rc_b;

    lpc_encode_avalon_ctl #(.FRAME_LEN(F2), .ORDER(O2), .DATA_W(16), .ADDR_W(AW2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .chipselect(cs_b), .read(read_b), .write(write_b),
        .address(addr_b), .writedata(wdata_b), .readdata(rdata_b), .irq(irq_b),
        .core_start(start_b), .core_rready(rready_b), .core_x_wen(wen_b),
        .core_x_waddr(xwa_b), .core_x_raddr(xra_b), .core_x_din(xdin_b),
        .core_x_dout(xdout_b), .core_res_raddr(rra_b), .core_res_dout(16'h0000),
        .core_a_rsel(rsel_b), .core_a_dout(adout_b));

    always @(posedge clock) if (wen_b) xmem_b[xwa_b] <= xdin_b;
    assign xdout_b = xmem_b[xra_b];
    always_comb begin
        adout_b = 32'h0;
        for (int i = 0; i < O2; i++) if (rsel_b[i]) adout_b = adout_b | {16'hC0DE, 16'(i)};
    end
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) rc_b <= 0;
        else if (start_b) rc_b <= 1;
        else if (rc_b != 0 && rc_b < 4) rc_b <= rc_b + 1;
    end
    assign rready_b = (rc_b == 4);

    task automatic bus_b(input logic r, input int a, input logic [15:0] d, input logic [15:0] e);
        addr_b = AW2'(a); wdata_b = d; cs_b = 1'b1; read_b = r; write_b = ~r;
        @(posedge clock); #1;
        cs_b = 1'b0; read_b = 1'b0; write_b = 1'b0;
        if (r) chk($sformatf("cfg2_rd_%0d", a), rdata_b, e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic wen;
        logic [7:0] wa;
        logic [15:0] d;
        logic [O-1:0] sel_exp;
        logic irq_pred;
        int a, sel, off;

        reset_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        cs_b = 1'b0; read_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0;
        for (int i = 0; i < O; i++) coef[i] = $urandom;
        coef[2] = 32'hDEADBEEF;
        err_m = 1'b0; done_m = 1'b0; rready_m = 1'b0; en_m = 2'b00; fcnt_m = 16'd0; cyc_m = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_core_start", core_start, 0);
        reset_n = 1'b1;
        cyc_end();
        rd_op(CB + 1, 16'h0000);
        rd_op(CB + 3, 16'h0000);
        rd_op(CB + 4, 16'h0000);
        rd_op(CB + 2, 16'h0000);

        // Fill X with its index, then read it back.
        for (int i = 0; i < F; i++) begin
            wr_op(i, 16'(i), wen, wa);
            chk("x_wen", wen, 1);
            chk("x_waddr", wa, i);
            x_ref[i] = 16'(i);
        end
        for (int i = 0; i < F; i++) rd_op(i, exp_rd(i));

        // Plain frame, core answers 50 cycles after start.
        run_frame(50, 0);
        rd_op(CB + 1, 16'h0005);
        rd_op(CB + 3, 16'h0001);
        rd_op(CB + 4, 16'd49);

        // Busy protection with the error interrupt enabled.
        wr_op(CB + 2, 16'h0002, wen, wa);
        en_m = 2'b10;
        run_frame(20, 1);
        chk("irq_err", irq, 1);
        rd_op(3, exp_rd(3));
        wr_op(CB + 1, 16'h0008, wen, wa);
        err_m = 1'b0;
        idle(2);
        chk("irq_cleared", irq, 0);

        // Coefficient halves and one-hot select.
        sel_exp = O'(4);
        addr = AW'(AB + 5); cs = 1'b1; rd = 1'b1; #1;
        chk("a_rsel", a_rsel, sel_exp);
        exp_q.push_back(16'hDEAD); tag_q.push_back(AB + 5);
        cyc_end();
        rd_op(AB + 4, 16'hBEEF);

        // Random idle traffic interleaved with random frames.
        idle(1);
        for (int f = 0; f < 8; f++) begin
            irq_pred = irq_f();
            for (int j = 0; j < 40; j++) begin
                chk("irq_idle", irq, irq_pred);
                irq_pred = irq_f();
                sel = $urandom_range(0, 3);
                d = 16'($urandom);
                if (sel == 0) begin
                    a = $urandom_range(0, (1 << AW) - 1);
                    rd_op(a, exp_rd(a));
                end else if (sel == 1) begin
                    a = $urandom_range(0, F - 1);
                    wr_op(a, d, wen, wa);
                    chk("x_wen_rand", wen, 1);
                    x_ref[a] = d;
                end else if (sel == 2) begin
                    wr_op($urandom_range(F, CB - 1), d, wen, wa);
                    err_m = 1'b1;
                end else begin
                    off = $urandom_range(0, 6);
                    if (off == 0) wr_op(CB, d & 16'hFFFE, wen, wa);
                    else if (off == 6) wr_op($urandom_range(CB + 6, (1 << AW) - 1), d, wen, wa);
                    else wr_op(CB + off, d, wen, wa);
                    if (off == 1 && d[2]) done_m = 1'b0;
                    if (off == 1 && d[3]) err_m = 1'b0;
                    if (off == 2) en_m = d[1:0];
                end
            end
            run_frame($urandom_range(2, 40), (f % 3 == 0) ? 0 : ((f % 3 == 1) ? 2 : 3));
        end

        // Reset in the middle of a run abandons the frame.
        wr_op(CB + 2, 16'h0002, wen, wa);
        wr_op(F + 7, 16'h1111, wen, wa);
        rd_op(AB + 4, 16'hBEEF);
        idle(2);
        chk("irq_pre_reset", irq, 1);
        n_cfg = 30;
        a = start_cnt;
        wr_op(CB, 16'h0001, wen, wa);
        idle(10);
        chk("sb_drained_pre_reset", exp_q.size(), 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_readdata", readdata, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_x_wen", core_x_wen, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        err_m = 1'b0; done_m = 1'b0; rready_m = 1'b0; en_m = 2'b00; fcnt_m = 16'd0; cyc_m = 32'd0;
        idle(40);
        rd_op(CB + 1, exp_rd(CB + 1));
        rd_op(CB + 3, exp_rd(CB + 3));
        rd_op(CB + 4, exp_rd(CB + 4));
        rd_op(CB + 2, exp_rd(CB + 2));
        chk("no_restart_after_reset", start_cnt - a, 1);

        // Relocated map in the larger configuration.
        addr_b = AW2'(255); wdata_b = 16'h1234; cs_b = 1'b1; write_b = 1'b1; #1;
        chk("cfg2_x_wen", wen_b, 1);
        chk("cfg2_x_waddr", xwa_b, 255);
        @(posedge clock); #1;
        cs_b = 1'b0; write_b = 1'b0;
        bus_b(1'b1, 255, 16'h0000, 16'h1234);
        bus_b(1'b0, CB2, 16'h0001, 16'h0000);
        chk("cfg2_core_start", start_b, 1);
        repeat (10) @(posedge clock);
        #1;
        bus_b(1'b1, CB2 + 3, 16'h0000, 16'h0001);
        bus_b(1'b1, CB2 + 4, 16'h0000, 16'h0003);
        bus_b(1'b1, CB2 + 1, 16'h0000, 16'h0005);
        addr_b = AW2'(CB2 - 1); cs_b = 1'b1; read_b = 1'b1; #1;
        chk("cfg2_a_rsel", rsel_b, 32'h0000_8000);
        @(posedge clock); #1;
        cs_b = 1'b0; read_b = 1'b0;
        chk("cfg2_a_hi", rdata_b, 16'hC0DE);
        bus_b(1'b1, CB2 - 2, 16'h0000, 16'h000F);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc_end();
        idle(2);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
